// File: rtl/led_pulse_stretch.sv
// Event-to-LED blink stretcher: fixed on time, fixed dark gap, queued replays.
// Optional rising-edge qualification of i_evt via `define LED_STRETCH_EDGE_EN.
module led_pulse_stretch #(
   parameter int unsigned ON_CYCLES      = 5_000_000,
   parameter int unsigned OFF_CYCLES     = 5_000_000,
   parameter int unsigned MAX_PENDING    = 7,
   parameter bit          LED_ACTIVE_LOW = 1'b0
) (
   input  logic                               i_clk,
   input  logic                               i_rst,
   input  logic                               i_evt,
   output logic                               o_led,
   output logic                               o_busy,
   output logic [$clog2(MAX_PENDING+1)-1:0]   o_pending,
   output logic                               o_overflow
);

   localparam int unsigned TMAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned PW   = $clog2(MAX_PENDING + 1);

   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_CYCLES - 1);
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ON,
      S_GAP
   } state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [PW-1:0] pend_q, pend_d;
   logic          ovf_q, ovf_d;
   logic          led_q;
   logic          fire;
   logic          inc, dec;

`ifdef LED_STRETCH_EDGE_EN
   logic evt_q;

   // Reset high so a level held through reset is not seen as an edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) evt_q <= 1'b1;
      else       evt_q <= i_evt;
   end

   assign fire = i_evt & ~evt_q;
`else
   assign fire = i_evt;
`endif

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pend_d  = pend_q;
      ovf_d   = ovf_q;
      inc     = 1'b0;
      dec     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (fire) begin
               state_d = S_ON;
               timer_d = ON_LOAD;
            end
         end
         S_ON: begin
            inc = fire;
            if (timer_q == '0) begin
               state_d = S_GAP;
               timer_d = OFF_LOAD;
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         S_GAP: begin
            inc = fire;
            if (timer_q == '0) begin
               if (pend_q != '0) begin
                  state_d = S_ON;
                  timer_d = ON_LOAD;
                  dec     = 1'b1;
               end else if (fire) begin
                  // Event starts the next blink directly instead of being queued.
                  state_d = S_ON;
                  timer_d = ON_LOAD;
                  inc     = 1'b0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               timer_d = timer_q - TW'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (inc && !dec) begin
         if (pend_q == PEND_MAX) ovf_d = 1'b1;
         else                    pend_d = pend_q + PW'(1);
      end else if (dec && !inc) begin
         pend_d = pend_q - PW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         timer_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         led_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         led_q   <= (state_d == S_ON);
      end
   end

   assign o_led      = led_q ^ LED_ACTIVE_LOW;
   assign o_busy     = (state_q != S_IDLE);
   assign o_pending  = pend_q;
   assign o_overflow = ovf_q;

endmodule
